// File: rtl/stream_pkg.sv
// Shared definitions for the streaming blocks: default beat width and a
// constant-foldable ceil(log2()) helper used for derived widths.
package stream_pkg;

    localparam int DATA_W_DEF = 8;

    // Returns 0 for n <= 1, so callers must guarantee n >= 2 where a
    // non-zero width is needed.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit of req searching last+1, last+2, ...
// modulo N_REQ, with last itself searched last.
module rr_pick
    import stream_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic found;
    int   j;

    always_comb begin
        any   = |req;
        idx   = last;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(last) + k) % N_REQ;
            if (!found && req[j]) begin
                idx   = IDX_W'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// N-to-1 valid/ready stream arbiter: round-robin with a bounded burst lock
// and a fully registered output stage (1 beat/cycle, no switch bubble).
module stream_rr_arbiter
    import stream_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_MAX = 4,
    localparam int IDX_W    = clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ*DATA_W-1:0] up_data,
    input  logic [N_REQ-1:0]        up_valid,
    output logic [N_REQ-1:0]        up_ready,
    output logic [DATA_W-1:0]       down_data,
    output logic                    down_valid,
    input  logic                    down_ready,
    output logic [IDX_W-1:0]        down_src
);

    localparam int CNT_W = clog2(BURST_MAX + 1);

    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  src_q, src_d;
    logic              valid_q, valid_d;

    logic              ld, locked, any, fire;
    logic [IDX_W-1:0]  rr_idx, sel;
    logic [CNT_W-1:0]  base, inc;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req  (up_valid),
        .last (cur_q),
        .any  (any),
        .idx  (rr_idx)
    );

    assign ld       = !valid_q || down_ready;
    assign locked   = (cnt_q != '0);
    // A live burst overrides the rotation as long as its owner keeps valid up.
    assign sel      = (locked && up_valid[cur_q]) ? cur_q : rr_idx;
    assign fire     = ld && any;
    assign up_ready = fire ? (N_REQ'(1) << sel) : '0;

    assign base = (locked && sel == cur_q) ? cnt_q : '0;
    assign inc  = base + 1'b1;

    always_comb begin
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        src_d   = src_q;
        valid_d = valid_q;
        if (fire) begin
            data_d  = up_data[sel*DATA_W +: DATA_W];
            src_d   = sel;
            valid_d = 1'b1;
            cur_d   = sel;
            cnt_d   = (inc == CNT_W'(BURST_MAX)) ? '0 : inc;
        end else if (ld) begin
            valid_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q   <= IDX_W'(N_REQ - 1);
            cnt_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            src_q   <= src_d;
            valid_q <= valid_d;
        end
    end

    assign down_data  = data_q;
    assign down_src   = src_q;
    assign down_valid = valid_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomized bench for stream_rr_arbiter: two instances (burst 4 and burst 1)
// share stimulus and are checked against a per-instance behavioural model.
module tb_stream_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] up_data = '0;
    logic [N-1:0]   up_valid = '0;
    logic           down_ready = 1'b0;

    logic [N-1:0]   ur0, ur1;
    logic [W-1:0]   dd0, dd1;
    logic           dv0, dv1;
    logic [1:0]     ds0, ds1;

    stream_rr_arbiter #(.N_REQ(N), .DATA_W(W), .BURST_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .up_data(up_data), .up_valid(up_valid),
        .up_ready(ur0), .down_data(dd0), .down_valid(dv0),
        .down_ready(down_ready), .down_src(ds0)
    );

    stream_rr_arbiter #(.N_REQ(N), .DATA_W(W), .BURST_MAX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .up_data(up_data), .up_valid(up_valid),
        .up_ready(ur1), .down_data(dd1), .down_valid(dv1),
        .down_ready(down_ready), .down_src(ds1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model state per instance: burst owner, beats it has used in the
    // current burst (0 = no live burst), and the output register contents.
    int own[2];
    int used[2];
    int bm[2] = '{4, 1};
    bit ov[2];
    int od[2];
    int os[2];

    function automatic int winner(input int m);
        if (used[m] > 0 && up_valid[own[m]]) return own[m];
        for (int k = 1; k <= N; k++)
            if (up_valid[(own[m] + k) % N]) return (own[m] + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            own[m] = N - 1; used[m] = 0; ov[m] = 1'b0; od[m] = 0; os[m] = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        up_valid = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle of inputs at the negedge, compare, advance model,
    // then wait for the following negedge (one posedge in between).
    task automatic step(input logic [N-1:0] v, input bit rdy, output logic [N-1:0] u0);
        int w;
        bit ld;
        logic [N-1:0] eu, au;
        logic [W-1:0] ad;
        logic av;
        logic [1:0] as;
        up_valid = v;
        down_ready = rdy;
        for (int i = 0; i < N; i++) up_data[i*W +: W] = W'($urandom);
        #1;
        for (int m = 0; m < 2; m++) begin
            au = (m == 0) ? ur0 : ur1;
            av = (m == 0) ? dv0 : dv1;
            ad = (m == 0) ? dd0 : dd1;
            as = (m == 0) ? ds0 : ds1;
            chk($sformatf("down_valid[%0d]", m), 32'(av), 32'(ov[m]));
            if (ov[m]) begin
                chk($sformatf("down_data[%0d]", m), 32'(ad), 32'(od[m]));
                chk($sformatf("down_src[%0d]", m), 32'(as), 32'(os[m]));
            end
            ld = !ov[m] || rdy;
            w  = winner(m);
            eu = (ld && w >= 0) ? (N'(1) << w) : '0;
            chk($sformatf("up_ready[%0d]", m), 32'(au), 32'(eu));
            if (ld && w >= 0) begin
                used[m] = (used[m] > 0 && w == own[m]) ? used[m] + 1 : 1;
                if (used[m] == bm[m]) used[m] = 0;
                own[m] = w;
                ov[m]  = 1'b1;
                od[m]  = int'(up_data[w*W +: W]);
                os[m]  = w;
            end else if (ld) begin
                ov[m]   = 1'b0;
                used[m] = 0;
            end
        end
        u0 = ur0;
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] u;
        logic [N-1:0] v;
        bit rdy;

        do_reset();
        chk("rst_valid0", 32'(dv0), 0);
        chk("rst_data0",  32'(dd0), 0);
        chk("rst_src0",   32'(ds0), 0);
        chk("rst_valid1", 32'(dv1), 0);

        // Single requester streaming, no gaps.
        repeat (8) step(4'b0001, 1'b1, u);

        // All valid: burst-4 vs pure round-robin source order.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            step(4'hF, 1'b1, u);
            chk("burst_seq", 32'(ds0), 32'((k / 4) % 4));
            chk("rr_seq",    32'(ds1), 32'(k % 4));
        end

        // Lone requester keeps getting the channel across burst boundaries.
        repeat (6) step(4'b0100, 1'b1, u);

        // Backpressure toggling with everyone valid.
        for (int k = 0; k < 16; k++) begin
            step(4'hF, bit'(k % 2), u);
            if (k % 2 == 0) chk("stall_ready", 32'(u), 0);
        end

        // Lock break: req1 locked at cnt=2 drops valid, req3 takes a fresh burst.
        do_reset();
        step(4'b0010, 1'b1, u); chk("lock_b0", 32'(u), 32'(4'b0010));
        step(4'b0010, 1'b1, u); chk("lock_b1", 32'(u), 32'(4'b0010));
        step(4'b1000, 1'b1, u); chk("lock_b2", 32'(u), 32'(4'b1000));
        step(4'b1010, 1'b1, u); chk("lock_b3", 32'(u), 32'(4'b1000));
        step(4'b1010, 1'b1, u); chk("lock_b4", 32'(u), 32'(4'b1000));
        step(4'b1010, 1'b1, u); chk("lock_b5", 32'(u), 32'(4'b1000));
        step(4'b1010, 1'b1, u); chk("lock_b6", 32'(u), 32'(4'b0010));

        // Random traffic with varying density and backpressure, plus an
        // asynchronous reset while the output register is full.
        for (int i = 0; i < 600; i++) begin
            case ((i / 100) % 3)
                0:       v = N'($urandom);
                1:       v = N'($urandom & $urandom);
                default: v = N'($urandom | $urandom);
            endcase
            rdy = ($urandom_range(0, 3) != 0);
            step(v, rdy, u);
            if (i == 300) begin
                step(4'hF, 1'b1, u);
                rst_n = 1'b0;
                #1;
                chk("async_rst_v0", 32'(dv0), 0);
                chk("async_rst_v1", 32'(dv1), 0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                step(4'hF, 1'b1, u);
                chk("post_rst_src", 32'(ds0), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one downstream valid/ready byte stream among N_REQ upstream valid/ready producers.
- Round-robin arbitration with a bounded burst lock: a granted requester keeps the channel for up to BURST_MAX consecutive beats while its valid stays high.
- Output is fully registered: 1-cycle latency, 1 beat/cycle sustained throughput.
- Sits in front of a valid_proxy-style pipeline stage that feeds a single consumer.

Parameters:
- N_REQ, 4, number of upstream requesters (>=2).
- DATA_W, 8, beat width in bits.
- BURST_MAX, 4, maximum consecutive beats per grant (>=1; 1 = pure round-robin).
- IDX_W, derived ceil(log2(N_REQ)), requester index width (not user-set).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- up_data  in  N_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W].
- up_valid  in  N_REQ  requester i has a beat.
- up_ready  out  N_REQ  beat from requester i accepted this cycle.
- down_data  out  DATA_W  registered output beat.
- down_valid  out  1  output register holds a beat.
- down_ready  in  1  consumer accepts down_data this cycle.
- down_src  out  IDX_W  index of the requester that produced down_data.

Behaviour:
- Reset values (async on rst_n=0):
  - down_valid=0, down_data=0, down_src=0.
  - cur=N_REQ-1, so requester 0 has first priority.
  - cnt=0, i.e. unlocked.
- Load enable: ld = !down_valid || down_ready.
- Selection (combinational):
  - locked = (cnt != 0).
  - If locked && up_valid[cur]: sel=cur.
  - Otherwise sel = first i with up_valid[i], searching cur+1, cur+2, ... mod N_REQ, with cur searched last.
  - any = |up_valid.
- up_ready[i] = ld && any && (sel == i). At most one bit is high. up_ready may depend combinationally on up_valid and down_ready.
- Fire: fire = ld && any. On posedge with fire:
  - down_data <= up_data[sel].
  - down_src <= sel.
  - down_valid <= 1.
  - cur <= sel.
  - base = (locked && sel==cur) ? cnt : 0.
  - cnt <= (base+1 == BURST_MAX) ? 0 : base+1.
- On posedge with ld && !any: down_valid <= 0; cnt <= 0.
- On posedge with !ld (stalled): down_data, down_src, down_valid, cur and cnt are all held; up_ready is all zero.
- Lock release:
  - The burst limit is reached: cnt returns to 0 and cur=sel, so the next search starts at sel+1. The same requester is picked again only if no other requester is valid; a new burst then starts.
  - The locked requester drops valid while ld=1: that cycle arbitrates among the others and base=0 for the new winner.
  - If nobody is valid while ld=1, cnt is cleared.
  - While stalled, a valid drop by the locked requester does not clear cnt.
- Upstream valid may deassert without a handshake. The arbiter never requires valid to be held.
- Throughput: with down_ready held 1, one beat transfers per cycle. There is no bubble on a grant switch.
- Ordering: beats from the same requester leave in acceptance order. No beat is duplicated or dropped.
- down_data and down_src are stable while down_valid && !down_ready.
- Reset mid-operation: the output register empties immediately. Any beat in the register is discarded; upstream has already seen its handshake, and this is the accepted behaviour.
- Widths: cnt is ceil(log2(BURST_MAX+1)) bits. Index increments wrap mod N_REQ, including for non-power-of-2 N_REQ.

Decomposition:
- Shared package (stream_pkg) holds:
  - clog2 helper function.
  - Default DATA_W=8.
- Sub-module rr_pick: purely combinational rotating priority picker.
  - Inputs: req[N_REQ], last[IDX_W].
  - Outputs: any, idx.
  - It is reused by later multi-source blocks.
- Main module contains only the cur/cnt state, the lock override and the output register.

Test Plan:
- Single requester: req0 sends 0,1,2,... continuously with down_ready=1 and BURST_MAX=4 → down_data 0,1,2,... every cycle, down_src=0, first beat one cycle after first up_valid, no gaps.
- All four requesters always valid, down_ready=1 → down_src sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0... and each source's data is consecutive.
- BURST_MAX=1, all valid → down_src 0,1,2,3,0,1,... Only req2 valid, repeatedly → down_src 2 every cycle, no starvation bubble.
- down_ready toggles 1,0,1,0 with all valid → down_data/down_src held during ready=0, up_ready all zero on stalled cycles, no beat lost or duplicated (scoreboard per source).
- Lock break: req1 locked at cnt=2 drops up_valid for one cycle while req3 is valid → next beat from req3, and req3 gets a fresh burst of 4.
- Assert rst_n=0 mid-burst with down_valid=1 → down_valid=0 asynchronously. After release with all valid, first beat has down_src=0.
